// File: rtl/enco_frame_ctrl.sv
// Frame sequencer: latches one message frame, feeds the parity generation unit,
// loads the parity shift register and streams the parity word out MSB-first.
module enco_frame_ctrl #(
  parameter int LM       = 2,
  parameter int M        = 5,
  parameter int CALC_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [LM-1:0] s_msg,
  input  logic [M-1:0]  s_frozen,
  output logic [LM-1:0] pgu_msg,
  output logic [M-1:0]  pgu_frozen,
  input  logic [M-1:0]  pgu_parity,
  output logic          psr_load,
  output logic          psr_ce,
  input  logic          psr_msb,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_data,
  output logic          m_last,
  output logic          busy,
  output logic [7:0]    frame_cnt
);

  localparam int             BW        = (M > 1) ? $clog2(M) : 1;
  localparam logic [BW-1:0]  LAST_BIT  = BW'(M - 1);
  localparam logic [3:0]     CALC_INIT = 4'(CALC_CYC - 1);

  typedef enum logic [1:0] {IDLE, CALC, CAPT, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    calc_cnt;
  logic [BW-1:0] bit_cnt;

  // Parity word goes straight from the generation unit into the shift register.
  logic unused_parity;
  assign unused_parity = ^pgu_parity;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    psr_load  = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) state_nxt = CALC;
      end
      CALC: begin
        if (calc_cnt == '0) state_nxt = CAPT;
      end
      CAPT: begin
        psr_load  = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        m_valid = 1'b1;
        m_last  = (bit_cnt == LAST_BIT);
        if (m_ready && m_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign psr_ce = m_valid & m_ready;
  assign m_data = psr_msb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pgu_msg    <= '0;
      pgu_frozen <= '0;
      calc_cnt   <= '0;
      bit_cnt    <= '0;
      frame_cnt  <= '0;
    end else begin
      if (state == IDLE && s_valid) begin
        pgu_msg    <= s_msg;
        pgu_frozen <= s_frozen;
        calc_cnt   <= CALC_INIT;
      end
      if (state == CALC && calc_cnt != '0) calc_cnt <= calc_cnt - 4'd1;
      if (state == CAPT) bit_cnt <= '0;
      if (psr_ce) begin
        if (m_last) frame_cnt <= frame_cnt + 8'd1;
        else        bit_cnt   <= bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_enco_frame_ctrl.sv
// Bench for enco_frame_ctrl: two instances (CALC_CYC=1 and 4) with a behavioural
// parity unit and shift register; streams compared against the parity word bits.
module tb_enco_frame_ctrl;

  localparam int LM = 2;
  localparam int M  = 5;
  localparam logic [M-1:0] SALT = 5'b10010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         s_valid, s_ready, psr_load, psr_ce, psr_msb;
  logic [1:0]         m_valid, m_ready, m_data, m_last, busy;
  logic [1:0][LM-1:0] s_msg, pgu_msg;
  logic [1:0][M-1:0]  s_frozen, pgu_frozen, pgu_parity;
  logic [1:0][7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt[2];

  // Parity unit stand-in: any fixed function of its inputs will do.
  function automatic logic [M-1:0] pgu_f(input logic [LM-1:0] msg, input logic [M-1:0] fz);
    return fz ^ SALT ^ M'(msg);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [M-1:0] sreg;
    enco_frame_ctrl #(.LM(LM), .M(M), .CALC_CYC(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid[g]), .s_ready(s_ready[g]), .s_msg(s_msg[g]), .s_frozen(s_frozen[g]),
      .pgu_msg(pgu_msg[g]), .pgu_frozen(pgu_frozen[g]), .pgu_parity(pgu_parity[g]),
      .psr_load(psr_load[g]), .psr_ce(psr_ce[g]), .psr_msb(psr_msb[g]),
      .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]), .m_last(m_last[g]),
      .busy(busy[g]), .frame_cnt(frame_cnt[g])
    );
    assign pgu_parity[g] = pgu_f(pgu_msg[g], pgu_frozen[g]);
    assign psr_msb[g]    = sreg[M-1];
    always @(posedge clk) begin
      if (psr_load[g])    sreg <= pgu_parity[g];
      else if (psr_ce[g]) sreg <= {sreg[M-2:0], 1'b0};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low in cycles 4..6 after accept.
  // abort_at >= 0 pulls reset while bit abort_at is on the wire.
  task automatic run_frame(input int d, input logic [LM-1:0] msg, input logic [M-1:0] fz,
                           input int mode, input int abort_at,
                           input logic nv, input logic [LM-1:0] nmsg, input logic [M-1:0] nfz);
    int calc;
    int k;
    int cyc;
    logic [M-1:0] par;
    calc = (d == 0) ? 1 : 4;
    par  = pgu_f(msg, fz);
    k    = 0;
    s_valid[d] = 1'b1; s_msg[d] = msg; s_frozen[d] = fz; m_ready[d] = 1'b1;
    #1;
    chk("accept_ready", {s_ready[d], busy[d], m_valid[d]}, 3'b100);
    step(); cyc = 1;
    s_valid[d] = nv; s_msg[d] = nmsg; s_frozen[d] = nfz;
    for (int c = 0; c < calc; c++) begin
      m_ready[d] = 1'($urandom_range(0, 1));
      #1;
      chk("calc_ctrl", {busy[d], s_ready[d], psr_load[d], psr_ce[d], m_valid[d]}, 5'b10000);
      chk("calc_pgu", {pgu_msg[d], pgu_frozen[d]}, {msg, fz});
      step(); cyc++;
    end
    m_ready[d] = 1'b1;
    #1;
    chk("capt_load", {psr_load[d], psr_ce[d], m_valid[d], s_ready[d]}, 4'b1000);
    step(); cyc++;
    for (int t = 0; t < 64 && k < M; t++) begin
      case (mode)
        0:       m_ready[d] = 1'b1;
        1:       m_ready[d] = ($urandom_range(0, 3) != 0);
        default: m_ready[d] = !(cyc >= 4 && cyc <= 6);
      endcase
      #1;
      chk("shift_ctrl", {m_valid[d], s_ready[d], busy[d], psr_load[d]}, 4'b1010);
      chk("shift_data", m_data[d], par[M-1-k]);
      chk("shift_last", m_last[d], 32'(k == M - 1));
      chk("shift_ce", psr_ce[d], m_ready[d]);
      chk("shift_pgu_hold", {pgu_msg[d], pgu_frozen[d]}, {msg, fz});
      if (abort_at == k) begin
        rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", {m_valid[d], psr_ce[d], busy[d], s_ready[d]}, 4'b0001);
        chk("rst_mid_cnt", frame_cnt[d], 32'(exp_cnt[d]));
        chk("rst_mid_pgu", {pgu_msg[d], pgu_frozen[d]}, '0);
        step();
        rst = 1'b1;
        m_ready[d] = 1'b1;
        return;
      end
      if (m_ready[d]) k++;
      step(); cyc++;
    end
    chk("frame_bits", k, M);
    exp_cnt[d] = (exp_cnt[d] + 1) % 256;
    m_ready[d] = 1'b1;
    chk("after_ctrl", {s_ready[d], m_valid[d], busy[d], psr_load[d]}, 4'b1000);
    chk("frame_cnt", frame_cnt[d], 32'(exp_cnt[d]));
  endtask

  initial begin
    s_valid = '0; m_ready = '1; s_msg = '0; s_frozen = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    rst = 1'b0;
    step(); step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_ctrl", {s_ready[d], busy[d], m_valid[d], psr_load[d], psr_ce[d], m_last[d]}, 6'b100000);
      chk("reset_cnt", frame_cnt[d], 0);
      chk("reset_pgu", {pgu_msg[d], pgu_frozen[d]}, '0);
    end
    rst = 1'b1;
    step();

    // Reset mid-SHIFT at bit 2, then a normal frame afterwards.
    run_frame(0, 2'b10, 5'b11001, 0, 2, 1'b0, '0, '0);
    step();
    run_frame(0, 2'b11, 5'b00111, 0, -1, 1'b0, '0, '0);
    // Backpressure in cycles 4..6.
    run_frame(0, 2'b11, 5'b00111, 2, -1, 1'b0, '0, '0);
    // Second frame held on s_valid while the first is busy.
    run_frame(0, 2'b11, 5'b00111, 0, -1, 1'b1, 2'b01, 5'b01010);
    run_frame(0, 2'b01, 5'b01010, 0, -1, 1'b0, '0, '0);
    // Frozen-pattern extremes.
    run_frame(0, 2'b10, '1, 1, -1, 1'b0, '0, '0);
    run_frame(0, 2'b01, '0, 1, -1, 1'b0, '0, '0);

    // Longer compute time.
    run_frame(1, 2'b10, 5'b01101, 0, -1, 1'b0, '0, '0);
    run_frame(1, LM'($urandom), M'($urandom), 1, -1, 1'b0, '0, '0);

    // Back-to-back frames up to the counter wrap.
    for (int n = 0; n < 300 && exp_cnt[0] != 255; n++)
      run_frame(0, LM'($urandom), M'($urandom), int'($urandom_range(0, 1)), -1, 1'b0, '0, '0);
    chk("wrap_255", frame_cnt[0], 255);
    run_frame(0, LM'($urandom), M'($urandom), 1, -1, 1'b0, '0, '0);
    chk("wrap_0", frame_cnt[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
